// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the EX forwarding / hazard control slice.
// Forward-select codes, control modes and fixed register numbers.
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_HOLD,
        CTL_FLUSH,
        CTL_STALL
    } ctl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/forward unit (slave).
interface hazard_forward_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              mem_busy;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write, id_mem_read,
               ex_branch_taken, mem_busy,
        input  fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write, id_mem_read,
               ex_branch_taken, mem_busy,
        output fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Forwarding select for one ALU operand: MEM result beats WB data, $0 is never forwarded.
module fwd_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_dest,
    output fwd_t              sel
);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    always_comb begin
        sel = FWD_REGFILE;
        if (mem_wr && mem_dest != ZERO && mem_dest == src)
            sel = FWD_MEM;
        else if (wb_wr && wb_dest != ZERO && wb_dest == src)
            sel = FWD_WB;
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand-forwarding control, load-use stall, branch flush and memory-busy freeze.
// Tracks dest/write-enable of EX, MEM and WB in shadow registers.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_forward_unit_if.slave bus
);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic              ex_wr, ex_memrd, mem_wr, mem_memrd, wb_wr;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              load_use;
    ctl_t              ctl;
    fwd_t              sel_a, sel_b;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs), .mem_wr(mem_wr), .mem_dest(mem_dest),
        .wb_wr(wb_wr), .wb_dest(wb_dest), .sel(sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rt), .mem_wr(mem_wr), .mem_dest(mem_dest),
        .wb_wr(wb_wr), .wb_dest(wb_dest), .sel(sel_b)
    );

    always_comb begin
        load_use = ex_memrd && ex_wr && ex_dest != ZERO &&
                   ((bus.id_use_rs && bus.id_rs == ex_dest) ||
                    (bus.id_use_rt && bus.id_rt == ex_dest));
        ctl = CTL_RUN;
        if (bus.mem_busy)
            ctl = CTL_HOLD;
        else if (bus.ex_branch_taken)
            ctl = CTL_FLUSH;
        else if (load_use)
            ctl = CTL_STALL;
    end

    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        case (ctl)
            CTL_HOLD: begin
                bus.pc_en    = 1'b0;
                bus.ifid_en  = 1'b0;
                bus.idex_en  = 1'b0;
                bus.exmem_en = 1'b0;
                bus.memwb_en = 1'b0;
            end
            CTL_FLUSH: begin
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end
            CTL_STALL: begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // Sources the ID instruction does not read are recorded as $0 so they can never
    // pick up a forward (keeps the load-in-MEM check free of false hits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dest   <= '0;
            ex_wr     <= 1'b0;
            ex_memrd  <= 1'b0;
            mem_dest  <= '0;
            mem_wr    <= 1'b0;
            mem_memrd <= 1'b0;
            wb_dest   <= '0;
            wb_wr     <= 1'b0;
        end else if (ctl != CTL_HOLD) begin
            if (ctl == CTL_FLUSH || ctl == CTL_STALL) begin
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_dest  <= '0;
                ex_wr    <= 1'b0;
                ex_memrd <= 1'b0;
            end else begin
                ex_rs    <= bus.id_use_rs ? bus.id_rs : ZERO;
                ex_rt    <= bus.id_use_rt ? bus.id_rt : ZERO;
                ex_dest  <= bus.id_dest;
                ex_wr    <= bus.id_reg_write;
                ex_memrd <= bus.id_mem_read;
            end
            mem_dest  <= ex_dest;
            mem_wr    <= ex_wr;
            mem_memrd <= ex_memrd;
            wb_dest   <= mem_dest;
            wb_wr     <= mem_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ctl == CTL_FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else if (ctl == CTL_STALL) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.fwd_a     = sel_a;
    assign bus.fwd_b     = sel_b;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

    // Load data is never ready in MEM; the load-use stall must keep this from happening.
    a_no_load_fwd_from_mem: assert property (@(posedge clk) disable iff (rst)
        !(mem_memrd && (sel_a == FWD_MEM || sel_b == FWD_MEM)));

endmodule
